// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter and the pipeline stages around it.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default RAM address/data widths (reused by the
//                             fetch and memory stages)
//   ST_*                    : 2-bit arbiter FSM encodings
//   CLIENT_*                : client ids (fetch = 0, memory = 1)
package ram_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic CLIENT_FETCH = 1'b0;
    localparam logic CLIENT_MEM   = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request from client 1 / client 0
//   en         : a grant may be issued this cycle
//   grant[1:0] : one-hot grant (combinational), all-zero when none
// last_grant resets to CLIENT_MEM so the first tie after reset goes to client 0.
module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = '0;
        if (en) begin
            if (req == 2'b11) begin
                grant = (last_grant == CLIENT_MEM) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= CLIENT_MEM;
        end else if (grant != 2'b00) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch stage (client 0,
// read-only) and the memory stage (client 1, read/write). One access at a time,
// round-robin, ready arrives RAM_LATENCY+2 cycles after the grant cycle.
// Ports:
//   ram_clk, rst                        : clock, asynchronous active-low reset
//   c0_req/c0_addr -> c0_ready/c0_data  : fetch-stage read port
//   c1_req/c1_we/c1_addr/c1_wdata
//                  -> c1_ready/c1_data  : memory-stage read/write port
//   ram_we/ram_addr/ram_din, ram_dout   : RAM interface (registered read data)
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RAM_LATENCY = 1
)
(
    input  logic              ram_clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic              c0_ready,
    output logic [DATA_W-1:0] c0_data,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ready,
    output logic [DATA_W-1:0] c1_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned     CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

    logic [1:0]       state;
    logic [1:0]       grant;
    logic             grant_id;
    logic             op_write;
    logic [CNT_W-1:0] wait_cnt;
    logic             arb_en;

    // Grants are only issued from IDLE; RESP never regrants a still-high req.
    assign arb_en = (state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk   (ram_clk),
        .rst_n (rst),
        .req   ({c1_req, c0_req}),
        .en    (arb_en),
        .grant (grant)
    );

    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            grant_id <= CLIENT_FETCH;
            op_write <= 1'b0;
            wait_cnt <= '0;
            c0_ready <= 1'b0;
            c1_ready <= 1'b0;
            c0_data  <= '0;
            c1_data  <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        grant_id <= grant[1];
                        op_write <= grant[1] & c1_we;
                        ram_we   <= grant[1] & c1_we;
                        ram_addr <= grant[1] ? c1_addr : c0_addr;
                        ram_din  <= grant[1] ? c1_wdata : '0;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // RAM samples at the end of this cycle; a write lasts one edge.
                    ram_we   <= 1'b0;
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        if (grant_id == CLIENT_FETCH) begin
                            if (!op_write) c0_data <= ram_dout;
                            c0_ready <= 1'b1;
                        end else begin
                            if (!op_write) c1_data <= ram_dout;
                            c1_ready <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    c0_ready <= 1'b0;
                    c1_ready <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter: one instance with
// RAM_LATENCY=1 and one with RAM_LATENCY=3, each backed by a behavioural RAM.
module tb_ram_port_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    // Instance A (RAM_LATENCY = 1)
    logic        c0_req = 1'b0;
    logic [15:0] c0_addr = '0;
    logic        c0_ready;
    logic [7:0]  c0_data;
    logic        c1_req = 1'b0;
    logic        c1_we = 1'b0;
    logic [15:0] c1_addr = '0;
    logic [7:0]  c1_wdata = '0;
    logic        c1_ready;
    logic [7:0]  c1_data;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    // Instance B (RAM_LATENCY = 3), fetch port only
    logic        b_c0_req = 1'b0;
    logic [15:0] b_c0_addr = '0;
    logic        b_c0_ready;
    logic [7:0]  b_c0_data;
    logic        b_c1_req = 1'b0;
    logic        b_c1_we = 1'b0;
    logic [15:0] b_c1_addr = '0;
    logic [7:0]  b_c1_wdata = '0;
    logic        b_c1_ready;
    logic [7:0]  b_c1_data;
    logic        b_ram_we;
    logic [15:0] b_ram_addr;
    logic [7:0]  b_ram_din;
    logic [7:0]  b_ram_dout;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int we_cycles    = 0;
    int c1_ready_cnt = 0;
    bit both_ready   = 1'b0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LATENCY(1)) dut (
        .ram_clk(clk), .rst(rst_n),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_ready(c0_ready), .c0_data(c0_data),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ready(c1_ready), .c1_data(c1_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LATENCY(3)) dut_lat3 (
        .ram_clk(clk), .rst(rst_n),
        .c0_req(b_c0_req), .c0_addr(b_c0_addr), .c0_ready(b_c0_ready), .c0_data(b_c0_data),
        .c1_req(b_c1_req), .c1_we(b_c1_we), .c1_addr(b_c1_addr), .c1_wdata(b_c1_wdata),
        .c1_ready(b_c1_ready), .c1_data(b_c1_data),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // Behavioural RAM A: registered read (old data on collision), 1-cycle latency.
    logic [7:0] mem1 [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem1[i] = 8'h00;
        mem1[16'h0000] = 8'h01;
        mem1[16'h0004] = 8'h02;
        mem1[16'h0005] = 8'h01;
        mem1[16'hFFFF] = 8'h7E;
        ram_dout = 8'h00;
        forever begin
            @(posedge clk);
            ram_dout <= mem1[ram_addr];
            if (ram_we) mem1[ram_addr] = ram_din;
        end
    end

    // Behavioural RAM B: 3-stage read pipeline.
    logic [7:0] mem3 [0:65535];
    logic [7:0] p0, p1;
    initial begin
        for (int i = 0; i < 65536; i++) mem3[i] = 8'h00;
        mem3[16'h0100] = 8'h3C;
        p0 = 8'h00; p1 = 8'h00; b_ram_dout = 8'h00;
        forever begin
            @(posedge clk);
            p0         <= mem3[b_ram_addr];
            p1         <= p0;
            b_ram_dout <= p1;
            if (b_ram_we) mem3[b_ram_addr] = b_ram_din;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) we_cycles <= we_cycles + 1;
        if (c1_ready) c1_ready_cnt <= c1_ready_cnt + 1;
        if (c0_ready && c1_ready) both_ready <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after ready.
    task automatic c0_xfer(input logic [15:0] a, output logic [7:0] d, output int rc);
        int n;
        c0_req  = 1'b1;
        c0_addr = a;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!c0_ready && n < 20);
        check("c0_ready_seen", {31'd0, c0_ready}, 32'd1);
        d  = c0_data;
        rc = cyc;
        @(posedge clk); #1;
        c0_req = 1'b0;
    endtask

    task automatic c1_xfer(input logic we, input logic [15:0] a, input logic [7:0] wd,
                           output logic [7:0] d, output int rc);
        int n;
        c1_req   = 1'b1;
        c1_we    = we;
        c1_addr  = a;
        c1_wdata = wd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!c1_ready && n < 20);
        check("c1_ready_seen", {31'd0, c1_ready}, 32'd1);
        d  = c1_data;
        rc = cyc;
        @(posedge clk); #1;
        c1_req = 1'b0;
        c1_we  = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int rc, start, snap, n;
        int rc0 [2];
        int rc1 [2];
        logic [7:0] fetch_exp [4];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_c0_ready", {31'd0, c0_ready}, 32'd0);
        check("rst_c1_ready", {31'd0, c1_ready}, 32'd0);
        check("rst_c0_data",  {24'd0, c0_data},  32'd0);
        check("rst_c1_data",  {24'd0, c1_data},  32'd0);
        check("rst_ram_we",   {31'd0, ram_we},   32'd0);
        check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        check("rst_ram_din",  {24'd0, ram_din},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single c0 read: ready only in grant cycle + 3, c1 silent
        c0_req  = 1'b1;
        c0_addr = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("t1_c0_ready", {31'd0, c0_ready}, (k == 3) ? 32'd1 : 32'd0);
            check("t1_c1_ready", {31'd0, c1_ready}, 32'd0);
            if (k == 3) check("t1_c0_data", {24'd0, c0_data}, 32'h01);
            if (k == 4) c0_req = 1'b0;
        end

        // c1 read, write, read-back
        c1_xfer(1'b0, 16'h0000, 8'h00, d, rc);
        check("t2_rd0_data", {24'd0, d}, 32'h01);
        snap  = we_cycles;
        start = cyc;
        c1_xfer(1'b1, 16'h0010, 8'hA5, d, rc);
        check("t2_wr_data_kept", {24'd0, d}, 32'h01);
        check("t2_wr_latency", rc - start, 3);
        check("t2_we_width", we_cycles - snap, 1);
        c1_xfer(1'b0, 16'h0010, 8'h00, d, rc);
        check("t2_rd_back", {24'd0, d}, 32'hA5);
        c1_xfer(1'b0, 16'hFFFF, 8'h00, d, rc);
        check("t2_rd_top_addr", {24'd0, d}, 32'h7E);

        // Continuous contention right after reset: c0,c1,c0,c1 with 4-cycle spacing
        apply_reset;
        start = cyc;
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    logic [7:0] dd;
                    c0_xfer(16'h0000, dd, rc0[i]);
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    logic [7:0] de;
                    c1_xfer(1'b0, 16'h0010, 8'h00, de, rc1[j]);
                end
            end
        join
        check("t3_first_c0", rc0[0] - start, 3);
        check("t3_c1_after_c0", rc1[0] - rc0[0], 4);
        check("t3_c0_after_c1", rc0[1] - rc1[0], 4);
        check("t3_c1_after_c0b", rc1[1] - rc0[1], 4);

        // Sequential fetches 0x0004..0x0007; c1_data must not move
        fetch_exp[0] = 8'h02; fetch_exp[1] = 8'h01;
        fetch_exp[2] = 8'h00; fetch_exp[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            c0_xfer(16'h0004 + 16'(i), d, rc);
            check("t4_fetch", {24'd0, d}, {24'd0, fetch_exp[i]});
        end
        check("t4_c1_data_kept", {24'd0, c1_data}, 32'hA5);

        // RAM_LATENCY=3 instance: ready 5 cycles after grant
        b_c0_req  = 1'b1;
        b_c0_addr = 16'h0100;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!b_c0_ready && n < 20);
        check("t5_lat3_cycles", n, 5);
        check("t5_lat3_data", {24'd0, b_c0_data}, 32'h3C);
        @(posedge clk); #1;
        b_c0_req = 1'b0;

        // Reset during ACCESS of a c1 write to 0x0020
        c1_req   = 1'b1;
        c1_we    = 1'b1;
        c1_addr  = 16'h0020;
        c1_wdata = 8'h5A;
        @(posedge clk); #1;
        check("t6_we_in_access", {31'd0, ram_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we_async_drop", {31'd0, ram_we}, 32'd0);
        check("t6_addr_cleared", {16'd0, ram_addr}, 32'd0);
        check("t6_c1_ready", {31'd0, c1_ready}, 32'd0);
        c1_req = 1'b0;
        c1_we  = 1'b0;
        snap = c1_ready_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_ready_pulse", c1_ready_cnt - snap, 0);
        start = cyc;
        c0_xfer(16'h0020, d, rc);
        check("t6_idle_latency", rc - start, 3);
        check("t6_mem_untouched", {24'd0, d}, 32'h00);

        check("excl_ready", {31'd0, both_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
